wb_arbiter_2m: RTL

//  Shares one Wishbone slave (instruction/data RAM) between two Wishbone masters: M0 = fetch stage, M1 = load/store stage.

---
 rtl/wb_arb_pkg.sv | 30 +++
 rtl/wb_timeout_ctr.sv | 38 +++
 rtl/wb_arbiter_2m.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GNT0   = 3'd1,
        ST_GNT1   = 3'd2,
        ST_ABORT0 = 3'd3,
        ST_ABORT1 = 3'd4
    } arb_state_e;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_END     = 3'b111;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_M0   = 2'b01;
    localparam gnt_t GNT_M1   = 2'b10;

    // A master stays granted through its abort cycle, where the error is delivered.
    function automatic gnt_t state_gnt(input arb_state_e st);
        case (st)
            ST_GNT0, ST_ABORT0: return GNT_M0;
            ST_GNT1, ST_ABORT1: return GNT_M1;
            default:            return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating stall counter; expire flags the last tolerated stalled cycle.
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT_CYC != 0) && enable && (cnt_q == CNT_LIM);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Round-robin arbiter sharing one Wishbone slave between fetch (M0) and load/store (M1),
// with cycle lock while CYC is held and a watchdog that aborts stalled slave cycles.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_o,
    input  logic [2:0]    m0_cti,
    output logic [DW-1:0] m0_dat_i,
    output logic          m0_ack,
    output logic          m0_err,
    output logic          m0_rty,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_o,
    input  logic [2:0]    m1_cti,
    output logic [DW-1:0] m1_dat_i,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          m1_rty,
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_o,
    output logic [2:0]    s_cti,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack,
    input  logic          s_err,
    input  logic          s_rty,
    output gnt_t          gnt
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;   // 1: M1 was granted most recently
    logic       s_term;
    logic       wdog_en;
    logic       wdog_clr;
    logic       wdog_expire;

    assign s_term   = s_ack | s_err | s_rty;
    assign wdog_en  = ((state_q == ST_GNT0) || (state_q == ST_GNT1)) && s_cyc && s_stb && !s_term;
    assign wdog_clr = s_term || (state_d != state_q);

    wb_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst),
        .enable (wdog_en),
        .clear  (wdog_clr),
        .expire (wdog_expire)
    );

    // Next state: grant held while the owner keeps CYC; handover goes straight to the waiter.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc && (!m1_cyc || last_gnt_q)) begin
                    state_d    = ST_GNT0;
                    last_gnt_d = 1'b0;
                end else if (m1_cyc) begin
                    state_d    = ST_GNT1;
                    last_gnt_d = 1'b1;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc) begin
                    if (m1_cyc) begin
                        state_d    = ST_GNT1;
                        last_gnt_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (wdog_expire) begin
                    state_d = ST_ABORT0;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc) begin
                    if (m0_cyc) begin
                        state_d    = ST_GNT0;
                        last_gnt_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (wdog_expire) begin
                    state_d = ST_ABORT1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Bus steering from the current state; abort cycles hide the slave and raise err.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_o  = '0;
        s_cti    = WB_CTI_CLASSIC;
        m0_dat_i = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rty   = 1'b0;
        m1_dat_i = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rty   = 1'b0;
        case (state_q)
            ST_GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_o  = m0_dat_o;
                s_cti    = m0_cti;
                m0_dat_i = s_dat_i;
                m0_ack   = s_ack;
                m0_err   = s_err;
                m0_rty   = s_rty;
            end
            ST_GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_o  = m1_dat_o;
                s_cti    = m1_cti;
                m1_dat_i = s_dat_i;
                m1_ack   = s_ack;
                m1_err   = s_err;
                m1_rty   = s_rty;
            end
            ST_ABORT0: m0_err = 1'b1;
            ST_ABORT1: m1_err = 1'b1;
            default: ;
        endcase
    end

    assign gnt = state_gnt(state_q);

endmodule
